// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC state encoding, alignment width, boot-counter sizing.
package cpu_pkg;

    typedef enum logic [0:0] {
        PC_BOOT = 1'b0,
        PC_RUN  = 1'b1
    } pc_state_e;

    localparam int unsigned PC_ALIGN_BITS = 2;

    // Bits needed to count 0..delay; never narrower than one bit.
    function automatic int unsigned boot_ctr_w(input int unsigned delay);
        int unsigned w;
        w = $clog2(delay + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pc_boot_ctr.sv
// Boot-hold sequencer: counts edges after reset release and raises pc_valid on entering RUN.
module pc_boot_ctr
    import cpu_pkg::*;
#(
    parameter int unsigned BOOT_DELAY = 1
) (
    input  logic clk,
    input  logic rst,
    output logic run,
    output logic pc_valid
);

    localparam int unsigned CW = boot_ctr_w(BOOT_DELAY);
    localparam pc_state_e RESET_STATE = (BOOT_DELAY == 0) ? PC_RUN : PC_BOOT;

    pc_state_e       state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            valid_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            cnt      <= '0;
            pc_valid <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            pc_valid <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            PC_BOOT: begin
                cnt_next = cnt + CW'(1);
                if (cnt_next == CW'(BOOT_DELAY))
                    state_next = PC_RUN;
            end
            PC_RUN:  state_next = PC_RUN;
            default: state_next = RESET_STATE;
        endcase
        valid_next = (state_next == PC_RUN);
    end

    assign run = (state == PC_RUN);

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with boot hold, stall, prioritised redirect and advance counter.
// Optional alignment enforcement enabled by defining PC_ALIGN_CHK_EN.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC  = '0,
    parameter int unsigned       BOOT_DELAY = 1,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] npc,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_pc,
    output logic [WIDTH-1:0] pc_reg,
    output logic [WIDTH-1:0] pc_prev,
    output logic             pc_valid,
    output logic [CNT_W-1:0] adv_cnt,
    output logic             align_err
);

    logic             run;
    logic             load;
    logic [WIDTH-1:0] load_raw;
    logic [WIDTH-1:0] load_val;

    pc_boot_ctr #(
        .BOOT_DELAY (BOOT_DELAY)
    ) u_boot_ctr (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .pc_valid (pc_valid)
    );

    // Redirect wins over stall; stall only suppresses the sequential load.
    assign load     = run && (redir_valid || !stall);
    assign load_raw = redir_valid ? redir_pc : npc;

`ifdef PC_ALIGN_CHK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        {{(WIDTH - PC_ALIGN_BITS){1'b1}}, {PC_ALIGN_BITS{1'b0}}};

    logic misaligned;

    assign misaligned = |load_raw[PC_ALIGN_BITS-1:0];
    assign load_val   = load_raw & ALIGN_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            align_err <= 1'b0;
        else if (load && misaligned)
            align_err <= 1'b1;
    end
`else
    assign load_val  = load_raw;
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= RESET_VEC;
            pc_prev <= RESET_VEC;
            adv_cnt <= '0;
        end else if (load) begin
            pc_reg  <= load_val;
            pc_prev <= pc_reg;
            adv_cnt <= adv_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: two instances cover BOOT_DELAY=1 and BOOT_DELAY=3/CNT_W=4.
module tb_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: legacy-compatible configuration
    logic        a_rst, a_stall, a_redir_valid;
    logic [31:0] a_npc, a_redir_pc, a_pc_reg, a_pc_prev, a_adv_cnt;
    logic        a_pc_valid, a_align_err;

    // Instance B: longer boot hold, high reset vector, narrow counter
    logic        b_rst, b_stall, b_redir_valid;
    logic [31:0] b_npc, b_redir_pc, b_pc_reg, b_pc_prev;
    logic [3:0]  b_adv_cnt;
    logic        b_pc_valid, b_align_err;

    pc_unit #(
        .WIDTH      (32),
        .RESET_VEC  (32'h0000_0000),
        .BOOT_DELAY (1),
        .CNT_W      (32)
    ) u_dut_a (
        .clk         (clk),
        .rst         (a_rst),
        .npc         (a_npc),
        .stall       (a_stall),
        .redir_valid (a_redir_valid),
        .redir_pc    (a_redir_pc),
        .pc_reg      (a_pc_reg),
        .pc_prev     (a_pc_prev),
        .pc_valid    (a_pc_valid),
        .adv_cnt     (a_adv_cnt),
        .align_err   (a_align_err)
    );

    pc_unit #(
        .WIDTH      (32),
        .RESET_VEC  (32'h8000_0000),
        .BOOT_DELAY (3),
        .CNT_W      (4)
    ) u_dut_b (
        .clk         (clk),
        .rst         (b_rst),
        .npc         (b_npc),
        .stall       (b_stall),
        .redir_valid (b_redir_valid),
        .redir_pc    (b_redir_pc),
        .pc_reg      (b_pc_reg),
        .pc_prev     (b_pc_prev),
        .pc_valid    (b_pc_valid),
        .adv_cnt     (b_adv_cnt),
        .align_err   (b_align_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic [31:0] prev,
                         input logic valid, input logic [31:0] cnt, input logic err);
        chk({tag, ".pc_reg"},    a_pc_reg,    pc);
        chk({tag, ".pc_prev"},   a_pc_prev,   prev);
        chk({tag, ".pc_valid"},  a_pc_valid,  valid);
        chk({tag, ".adv_cnt"},   a_adv_cnt,   cnt);
        chk({tag, ".align_err"}, a_align_err, err);
    endtask

    task automatic chk_b(input string tag, input logic [31:0] pc, input logic [31:0] prev,
                         input logic valid, input logic [3:0] cnt);
        chk({tag, ".pc_reg"},   b_pc_reg,   pc);
        chk({tag, ".pc_prev"},  b_pc_prev,  prev);
        chk({tag, ".pc_valid"}, b_pc_valid, valid);
        chk({tag, ".adv_cnt"},  b_adv_cnt,  cnt);
    endtask

    logic [31:0] mis_load;
    logic        err_exp;

    initial begin
`ifdef PC_ALIGN_CHK_EN
        mis_load = 32'h10;
        err_exp  = 1'b1;
`else
        mis_load = 32'h13;
        err_exp  = 1'b0;
`endif
        a_rst = 1'b1; a_npc = 32'h4; a_stall = 1'b0; a_redir_valid = 1'b0; a_redir_pc = '0;
        b_rst = 1'b1; b_npc = 32'h200; b_stall = 1'b0; b_redir_valid = 1'b0; b_redir_pc = '0;
        repeat (3) tick();

        // ---------------- Instance A ----------------
        chk_a("a_reset", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
        a_rst = 1'b0;
        tick();
        chk_a("a_edge1", 32'h0, 32'h0, 1'b1, 32'd0, 1'b0);
        tick();
        chk_a("a_edge2", 32'h4, 32'h0, 1'b1, 32'd1, 1'b0);

        a_npc = 32'h20; a_stall = 1'b1;
        tick();
        chk_a("a_stall1", 32'h4, 32'h0, 1'b1, 32'd1, 1'b0);
        tick();
        chk_a("a_stall2", 32'h4, 32'h0, 1'b1, 32'd1, 1'b0);
        a_stall = 1'b0;
        tick();
        chk_a("a_unstall", 32'h20, 32'h4, 1'b1, 32'd2, 1'b0);

        a_redir_valid = 1'b1; a_redir_pc = 32'h100; a_stall = 1'b1; a_npc = 32'h24;
        tick();
        chk_a("a_redir", 32'h100, 32'h20, 1'b1, 32'd3, 1'b0);
        a_redir_valid = 1'b0; a_stall = 1'b0;
        tick();
        chk_a("a_post_redir", 32'h24, 32'h100, 1'b1, 32'd4, 1'b0);

        a_npc = 32'h13;
        tick();
        chk_a("a_misalign", mis_load, 32'h24, 1'b1, 32'd5, err_exp);
        a_npc = 32'h40;
        tick();
        chk_a("a_err_sticky", 32'h40, mis_load, 1'b1, 32'd6, err_exp);

        // Asynchronous reset between edges must clear outputs without a clock edge
        #2;
        a_rst = 1'b1;
        #1;
        chk_a("a_async_rst", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
        tick();
        chk_a("a_rst_hold", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);

        // ---------------- Instance B ----------------
        chk_b("b_reset", 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd0);
        chk("b_reset.align_err", b_align_err, 1'b0);
        b_rst = 1'b0; b_redir_valid = 1'b1; b_redir_pc = 32'h300;
        tick();
        chk_b("b_edge1", 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd0);
        tick();
        chk_b("b_edge2", 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd0);
        b_redir_valid = 1'b0;
        tick();
        chk_b("b_edge3", 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd0);
        tick();
        chk_b("b_edge4", 32'h200, 32'h8000_0000, 1'b1, 4'd1);

        // 14 more advances take the 4-bit counter to 15, one more wraps it to 0
        for (int k = 1; k <= 14; k++) begin
            b_npc = 32'h200 + 32'(k) * 32'd4;
            tick();
        end
        chk_b("b_cnt15", 32'h238, 32'h234, 1'b1, 4'd15);
        b_npc = 32'h23C;
        tick();
        chk_b("b_wrap", 32'h23C, 32'h238, 1'b1, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
